// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding and FSM state constants for the multiword add/sub unit
package alu_pkg;

  // Arithmetic operation selector, sampled when a request is accepted
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } op_t;

  // Sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Subtract-class ops feed the inverted second operand into the adder
  function automatic logic is_sub_op(input op_t o);
    return (o == OP_SUB) || (o == OP_SBC);
  endfunction

endpackage

// File: rtl/addsub_limb.sv
// rtl/addsub_limb.sv - combinational one-limb adder exposing carry into and out of the MSB
module addsub_limb #(
  parameter int LIMB_W = 32
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);

  logic [LIMB_W-1:0] low;
  logic [1:0]        top;

  // Split the add at the MSB so the carry into it is visible for signed overflow
  always_comb begin
    low   = {1'b0, a[LIMB_W-2:0]} + {1'b0, b[LIMB_W-2:0]} + {{(LIMB_W-1){1'b0}}, cin};
    c_msb = low[LIMB_W-1];
    top   = {1'b0, a[LIMB_W-1]} + {1'b0, b[LIMB_W-1]} + {1'b0, c_msb};
    sum   = {top[0], low[LIMB_W-2:0]};
    cout  = top[1];
  end

endmodule

// File: rtl/multiword_addsub_seq.sv
// rtl/multiword_addsub_seq.sv - limb-serial ADD/ADC/SUB/SBC with NZCV flags; ADDSUB_RSB_EN adds rev (RSB/RSC)
module multiword_addsub_seq
  import alu_pkg::*;
#(
  parameter int LIMB_W    = 32,
  parameter int NUM_LIMBS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic                        c_in,
  input  logic [LIMB_W*NUM_LIMBS-1:0] a,
  input  logic [LIMB_W*NUM_LIMBS-1:0] b,
`ifdef ADDSUB_RSB_EN
  input  logic                        rev,
`endif
  output logic                        ready,
  output logic                        done,
  output logic [LIMB_W*NUM_LIMBS-1:0] s,
  output logic                        n,
  output logic                        z,
  output logic                        c,
  output logic                        v
);

  localparam int OPW  = LIMB_W * NUM_LIMBS;
  localparam int IDXW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LIMBS - 1);

  logic [1:0]                         state;
  logic [NUM_LIMBS-1:0][LIMB_W-1:0]   a_q;
  logic [NUM_LIMBS-1:0][LIMB_W-1:0]   b_q;
  logic [NUM_LIMBS-1:0][LIMB_W-1:0]   s_q;
  logic [IDXW-1:0]                    idx;
  logic                               carry;
  logic                               zacc;

  op_t              op_e;
  logic             rev_i;
  logic             swap;
  logic [OPW-1:0]   opa;
  logic [OPW-1:0]   opb;
  logic             cin0;
  logic [LIMB_W-1:0] limb_sum;
  logic             limb_cout;
  logic             limb_cmsb;
  logic             limb_zero;

`ifdef ADDSUB_RSB_EN
  assign rev_i = rev;
`else
  assign rev_i = 1'b0;
`endif

  assign op_e = op_t'(op);

  // Operand steering and initial carry chosen at accept time
  always_comb begin
    swap = is_sub_op(op_e) && rev_i;
    opa  = swap ? b : a;
    opb  = swap ? a : b;
    if (is_sub_op(op_e)) opb = ~opb;
    case (op_e)
      OP_ADD:  cin0 = 1'b0;
      OP_ADC:  cin0 = c_in;
      OP_SUB:  cin0 = 1'b1;
      default: cin0 = c_in;
    endcase
  end

  addsub_limb #(.LIMB_W(LIMB_W)) u_limb (
    .a     (a_q[idx]),
    .b     (b_q[idx]),
    .cin   (carry),
    .sum   (limb_sum),
    .cout  (limb_cout),
    .c_msb (limb_cmsb)
  );

  assign limb_zero = (limb_sum == '0);

  // Sequencer: accept, one limb per edge with chained carry, flags from the last limb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      n     <= 1'b0;
      z     <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= opa;
            b_q   <= opb;
            idx   <= '0;
            carry <= cin0;
            zacc  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_q[idx] <= limb_sum;
          carry    <= limb_cout;
          zacc     <= zacc & limb_zero;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            n     <= limb_sum[LIMB_W-1];
            z     <= zacc & limb_zero;
            c     <= limb_cout;
            v     <= limb_cmsb ^ limb_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign s     = s_q;

endmodule
